// File: rtl/tlp_recv.sv
// RX TLP parser: decodes 1-DW MRd32/MWr32 into tlp_xcvr_pkg::Action records buffered in a small FIFO.
// Optional statistics counters are built only when TLP_RECV_STATS_EN is defined.
package tlp_xcvr_pkg;
  typedef logic [1:0] Channel;
  typedef logic [$bits(Channel):0] ChanIdx;
  typedef enum logic [1:0] {ACT_NONE = 2'd0, ACT_READ = 2'd1, ACT_WRITE = 2'd2, ACT_ERROR = 2'd3} ActKind;
  localparam logic [31:0] ERR_LENGTH  = 32'd1;
  localparam logic [31:0] ERR_TYPE    = 32'd2;
  localparam logic [31:0] ERR_FRAMING = 32'd3;
  typedef struct packed {
    ActKind      kind;
    logic [15:0] req_id;
    logic [7:0]  tag;
    ChanIdx      chan;
    logic [31:0] data;
  } Action;
endpackage

module tlp_recv
  import tlp_xcvr_pkg::*;
#(
  parameter int ACT_DEPTH = 4,
  parameter int ADDR_LSB  = 2
) (
  input  logic        pcieClk_in,
  input  logic        pcieRst_in,
  input  logic [63:0] rxData_in,
  input  logic        rxValid_in,
  output logic        rxReady_out,
  input  logic        rxSOP_in,
  input  logic        rxEOP_in,
  output Action       actData_out,
  output logic        actValid_out,
  input  logic        actReady_in,
  output logic [15:0] rxTlpCount_out,
  output logic [15:0] rxErrCount_out,
  output logic [1:0]  dbgState_out
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR1 = 2'd1, S_DATA = 2'd2, S_DRAIN = 2'd3} state_e;

  localparam int PTR_W = $clog2(ACT_DEPTH);
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(ACT_DEPTH - 2);

  state_e           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [15:0]      req_id_q, req_id_d;
  logic [7:0]       tag_q, tag_d;
  ChanIdx           chan_q, chan_d;
  logic             rx_ready_q;
  logic             beat, push, pop;
  Action            push_act;
  Action            mem_q [ACT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic [1:0]  fmt;
  logic [4:0]  typ;
  logic [9:0]  len;
  ChanIdx      chan;

  function automatic Action mk_err(input logic [31:0] code);
    Action a;
    a      = '0;
    a.kind = ACT_ERROR;
    a.data = code;
    return a;
  endfunction

  function automatic Action mk_read(input logic [15:0] rid, input logic [7:0] t, input ChanIdx c);
    Action a;
    a        = '0;
    a.kind   = ACT_READ;
    a.req_id = rid;
    a.tag    = t;
    a.chan   = c;
    return a;
  endfunction

  function automatic Action mk_write(input ChanIdx c, input logic [31:0] d);
    Action a;
    a      = '0;
    a.kind = ACT_WRITE;
    a.chan = c;
    a.data = d;
    return a;
  endfunction

  // QW0 holds the header DW0/DW1; on QW1 the low DW is the address.
  assign fmt  = rxData_in[30:29];
  assign typ  = rxData_in[28:24];
  assign len  = rxData_in[9:0];
  assign chan = rxData_in[ADDR_LSB +: $bits(ChanIdx)];

  assign beat         = rxValid_in & rx_ready_q;
  assign actValid_out = (count_q != '0);
  assign pop          = actValid_out & actReady_in;
  assign actData_out  = mem_q[rd_ptr_q];
  assign rxReady_out  = rx_ready_q;
  assign dbgState_out = state_q;

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    req_id_d = req_id_q;
    tag_d    = tag_q;
    chan_d   = chan_q;
    push     = 1'b0;
    push_act = '0;
    if (beat) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxSOP_in) begin
            push = 1'b1; push_act = mk_err(ERR_FRAMING);
          end else begin
            is_wr_d  = fmt[1];
            req_id_d = rxData_in[63:48];
            tag_d    = rxData_in[47:40];
            if (typ != 5'd0 || fmt[0]) begin
              push = 1'b1; push_act = mk_err(ERR_TYPE);
            end else if (len != 10'd1) begin
              push = 1'b1; push_act = mk_err(ERR_LENGTH);
            end else if (rxEOP_in) begin
              push = 1'b1; push_act = mk_err(ERR_FRAMING);
            end else begin
              state_d = S_HDR1;
            end
          end
        end
        S_HDR1: begin
          if (rxSOP_in) begin
            push = 1'b1; push_act = mk_err(ERR_FRAMING);
          end else if (is_wr_q && !rxData_in[2]) begin
            // Data DW lives in the next QW; an EOP here truncates the write.
            if (rxEOP_in) begin
              push = 1'b1; push_act = mk_err(ERR_FRAMING);
            end else begin
              chan_d  = chan;
              state_d = S_DATA;
            end
          end else begin
            push     = 1'b1;
            push_act = is_wr_q ? mk_write(chan, rxData_in[63:32]) : mk_read(req_id_q, tag_q, chan);
          end
        end
        S_DATA: begin
          push     = 1'b1;
          push_act = rxSOP_in ? mk_err(ERR_FRAMING) : mk_write(chan_q, rxData_in[31:0]);
        end
        S_DRAIN: begin
          if (rxEOP_in) state_d = S_IDLE;
        end
      endcase
      if (push) state_d = rxEOP_in ? S_IDLE : S_DRAIN;
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      req_id_q   <= '0;
      tag_q      <= '0;
      chan_q     <= '0;
      rx_ready_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      req_id_q   <= req_id_d;
      tag_q      <= tag_d;
      chan_q     <= chan_d;
      // Ready looks at the pre-push count; a TLP pushes at most once, so two pushes can never overflow.
      rx_ready_q <= (count_q <= READY_MAX);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (push) mem_q[wr_ptr_q] <= push_act;
  end

`ifdef TLP_RECV_STATS_EN
  logic [15:0] tlp_cnt_q, err_cnt_q;

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      tlp_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (beat && rxSOP_in && tlp_cnt_q != 16'hFFFF) tlp_cnt_q <= tlp_cnt_q + 16'd1;
      if (push && push_act.kind == ACT_ERROR && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign rxTlpCount_out = tlp_cnt_q;
  assign rxErrCount_out = err_cnt_q;
`else
  assign rxTlpCount_out = '0;
  assign rxErrCount_out = '0;
`endif

endmodule

// File: tb/tb_tlp_recv.sv
// Directed bench for tlp_recv: driver tasks push expected actions into a queue, an independent
// monitor pops and compares each action the DUT hands out.
module tb_tlp_recv;
  import tlp_xcvr_pkg::*;

  localparam int ACT_W = $bits(Action);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;
  logic        act_ready = 1'b0;
  logic        rx_ready;
  Action       act_data;
  logic        act_valid;
  logic [15:0] tlp_cnt, err_cnt;
  logic [1:0]  dbg_state;

  logic [ACT_W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int tlps_sent = 0;

  tlp_recv #(.ACT_DEPTH(4), .ADDR_LSB(2)) dut (
    .pcieClk_in     (clk),
    .pcieRst_in     (rst),
    .rxData_in      (rx_data),
    .rxValid_in     (rx_valid),
    .rxReady_out    (rx_ready),
    .rxSOP_in       (rx_sop),
    .rxEOP_in       (rx_eop),
    .actData_out    (act_data),
    .actValid_out   (act_valid),
    .actReady_in    (act_ready),
    .rxTlpCount_out (tlp_cnt),
    .rxErrCount_out (err_cnt),
    .dbgState_out   (dbg_state)
  );

  // clock / reset
  always #4 clk = ~clk;

  // expected-action builders
  function automatic logic [ACT_W-1:0] e_write(input logic [2:0] c, input logic [31:0] d);
    Action a;
    a = '0; a.kind = ACT_WRITE; a.chan = c; a.data = d;
    return a;
  endfunction

  function automatic logic [ACT_W-1:0] e_read(input logic [15:0] r, input logic [7:0] t, input logic [2:0] c);
    Action a;
    a = '0; a.kind = ACT_READ; a.req_id = r; a.tag = t; a.chan = c;
    return a;
  endfunction

  function automatic logic [ACT_W-1:0] e_err(input logic [31:0] code);
    Action a;
    a = '0; a.kind = ACT_ERROR; a.data = code;
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_beat(input logic [63:0] d, input logic sop, input logic eop);
    int waits = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      rx_data = d; rx_valid = 1'b1; rx_sop = sop; rx_eop = eop;
      if (rx_ready) done = 1;
      else if (++waits > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL beat_timeout: rx_ready stuck at 0 for %0d cycles, required 1", waits);
        done = 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  // MWr32 with addr[2]=1: data rides in the upper half of QW1
  task automatic mwr_hi(input logic [31:0] addr, input logic [31:0] d);
    send_beat({32'h0000_000F, 32'h4000_0001}, 1'b1, 1'b0);
    send_beat({d, addr}, 1'b0, 1'b1);
    tlps_sent++;
  endtask

  // MWr32 with addr[2]=0: data in the low half of QW2
  task automatic mwr_lo(input logic [31:0] addr, input logic [31:0] d);
    send_beat({32'h0000_000F, 32'h4000_0001}, 1'b1, 1'b0);
    send_beat({32'h0, addr}, 1'b0, 1'b0);
    send_beat({32'h0, d}, 1'b0, 1'b1);
    tlps_sent++;
  endtask

  task automatic mrd(input logic [15:0] rid, input logic [7:0] tag, input logic [31:0] addr);
    send_beat({rid, tag, 8'h0F, 32'h0000_0001}, 1'b1, 1'b0);
    send_beat({32'h0, addr}, 1'b0, 1'b1);
    tlps_sent++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d actions outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [ACT_W-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && act_valid && act_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL act_unexpected: got %0h with no action outstanding", act_data);
        end else begin
          exp = exp_q.pop_front();
          if (act_data !== exp) begin
            n_fail++;
            $display("FAIL act_data: got %0h expected %0h", act_data, exp);
          end
        end
      end
    end
  end

  initial begin
    do_reset();
    check("reset_act_valid", 64'(act_valid), 64'd0);
    check("reset_rx_ready", 64'(rx_ready), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_tlp_cnt", 64'(tlp_cnt), 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk);
    check("ready_after_reset", 64'(rx_ready), 64'd1);
    act_ready = 1'b1;

    // 2-beat write, 3-beat write, read
    exp_q.push_back(e_write(3'd3, 32'hCAFE_F00D));
    mwr_hi(32'h0000_000C, 32'hCAFE_F00D);
    exp_q.push_back(e_write(3'd2, 32'h1234_5678));
    mwr_lo(32'h0000_0008, 32'h1234_5678);
    exp_q.push_back(e_read(16'h0100, 8'h2A, 3'd1));
    mrd(16'h0100, 8'h2A, 32'h0000_0004);
    idle();
    wait_drain();

    // length error, type error, EOP on QW0, then a normal write on chan 5
    exp_q.push_back(e_err(32'd1));
    send_beat({32'h0000_000F, 32'h4000_0004}, 1'b1, 1'b0);
    send_beat({32'h0, 32'h0000_0010}, 1'b0, 1'b0);
    send_beat({32'h0, 32'h1111_2222}, 1'b0, 1'b1);
    exp_q.push_back(e_err(32'd2));
    send_beat({32'h0000_000F, 32'h6000_0001}, 1'b1, 1'b0);
    send_beat({32'h0, 32'h0000_0004}, 1'b0, 1'b1);
    exp_q.push_back(e_err(32'd3));
    send_beat({32'h0000_000F, 32'h0000_0001}, 1'b1, 1'b1);
    exp_q.push_back(e_write(3'd5, 32'hA5A5_0001));
    mwr_hi(32'h0000_0014, 32'hA5A5_0001);
    idle();
    wait_drain();

    // back-pressure: 8 back-to-back writes while the sink stalls
    act_ready = 1'b0;
    tlps_sent = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          exp_q.push_back(e_write(3'(1 + 2 * i), 32'hD000_0000 + 32'(i)));
          mwr_hi(32'h4 + 32'(8 * i), 32'hD000_0000 + 32'(i));
        end
        idle();
      end
      begin
        repeat (30) @(negedge clk);
        check("stall_rx_ready", 64'(rx_ready), 64'd0);
        check("stall_tlps_accepted", 64'(tlps_sent), 64'd3);
        check("stall_act_valid", 64'(act_valid), 64'd1);
        act_ready = 1'b1;
      end
    join
    wait_drain();
    check("burst_tlps_accepted", 64'(tlps_sent), 64'd8);

    // framing: stray beat while idle, SOP inside S_DATA, then recovery
    exp_q.push_back(e_err(32'd3));
    send_beat(64'hDEAD_BEEF_0000_0000, 1'b0, 1'b1);
    exp_q.push_back(e_err(32'd3));
    send_beat({32'h0000_000F, 32'h4000_0001}, 1'b1, 1'b0);
    send_beat({32'h0, 32'h0000_0008}, 1'b0, 1'b0);
    send_beat({32'h0000_000F, 32'h4000_0001}, 1'b1, 1'b1);
    exp_q.push_back(e_read(16'h0BEE, 8'h07, 3'd6));
    mrd(16'h0BEE, 8'h07, 32'h0000_0018);
    idle();
    wait_drain();

    // reset mid-packet with an action still queued: both must vanish
    act_ready = 1'b0;
    mwr_hi(32'h0000_0004, 32'h5555_AAAA);
    send_beat({32'h0000_000F, 32'h4000_0001}, 1'b1, 1'b0);
    @(negedge clk);
    check("prereset_act_valid", 64'(act_valid), 64'd1);
    rst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_act_valid", 64'(act_valid), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    act_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst_act_valid", 64'(act_valid), 64'd0);

    // stats: 3 good + 1 bad TLP from a clean reset
    do_reset();
    @(negedge clk);
    exp_q.push_back(e_write(3'd3, 32'h0000_0001));
    mwr_hi(32'h0000_000C, 32'h0000_0001);
    exp_q.push_back(e_write(3'd0, 32'h0000_0002));
    mwr_lo(32'h0000_0000, 32'h0000_0002);
    exp_q.push_back(e_read(16'h0001, 8'h01, 3'd7));
    mrd(16'h0001, 8'h01, 32'h0000_001C);
    exp_q.push_back(e_err(32'd1));
    send_beat({32'h0000_000F, 32'h4000_0002}, 1'b1, 1'b0);
    send_beat({32'h0, 32'h0000_0004}, 1'b0, 1'b1);
    idle();
    wait_drain();
`ifdef TLP_RECV_STATS_EN
    check("stats_tlp_cnt", 64'(tlp_cnt), 64'd4);
    check("stats_err_cnt", 64'(err_cnt), 64'd1);
`else
    check("stats_tlp_cnt", 64'(tlp_cnt), 64'd0);
    check("stats_err_cnt", 64'(err_cnt), 64'd0);
`endif
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_act_valid", 64'(act_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
